// File: rtl/hsi_mse_pkg.sv
// -----------------------------------------------------------------------------
// hsi_mse_pkg
// Shared constants and types for the HSI MSE engine.
//   HM_DATA_PER_WORD    default number of pixel elements per packed word
//   HM_MSE_PIPE_STAGES  depth of the |a-b| -> square -> accumulate pipeline
//   hsi_mse_lanes_state_t  run-control states of hsi_mse_lanes
// -----------------------------------------------------------------------------
package hsi_mse_pkg;

  localparam int HM_DATA_PER_WORD   = 2;
  localparam int HM_MSE_PIPE_STAGES = 3;

  typedef enum logic [2:0] {
    MSE_IDLE,
    MSE_ACCUM,
    MSE_DRAIN,
    MSE_DIVIDE,
    MSE_DONE
  } hsi_mse_lanes_state_t;

endpackage : hsi_mse_pkg

// File: rtl/hsi_mse_seq_div.sv
// -----------------------------------------------------------------------------
// hsi_mse_seq_div
// Sequential restoring unsigned divider, one quotient bit per clock.
// A start_i pulse loads the operands; DIVIDEND_W cycles later done_o pulses
// for one cycle with the (truncated) quotient on quotient_o, held until the
// next start_i. The divisor must be nonzero.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear_i         synchronous abort of a division in progress
//   start_i         load dividend_i / divisor_i and begin
//   dividend_i      DIVIDEND_W-bit numerator
//   divisor_i       DIVISOR_W-bit denominator
//   busy_o          iteration in progress
//   done_o          one-cycle pulse when the quotient is final
//   quotient_o      low QUOT_W bits of the quotient
// -----------------------------------------------------------------------------
module hsi_mse_seq_div #(
  parameter int DIVIDEND_W = 48,
  parameter int DIVISOR_W  = 10,
  parameter int QUOT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [QUOT_W-1:0]     quotient_o
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  // quot_q starts as the dividend and is shifted left each step; the freed
  // LSBs collect quotient bits while the MSBs feed the partial remainder.
  logic [DIVIDEND_W-1:0] quot_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  busy_q;
  logic                  done_q;

  // Remainder before the shift is below the divisor, so one extra bit holds it.
  logic [DIVISOR_W:0]    rem_shift;
  logic                  fits;
  logic [DIVISOR_W-1:0]  rem_next;

  assign rem_shift = {rem_q, quot_q[DIVIDEND_W-1]};
  assign fits      = (rem_shift >= {1'b0, dvs_q});
  assign rem_next  = fits ? DIVISOR_W'(rem_shift - {1'b0, dvs_q})
                          : rem_shift[DIVISOR_W-1:0];

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (clear_i) begin
      quot_q <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        quot_q <= dividend_i;
        rem_q  <= '0;
        dvs_q  <= divisor_i;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        quot_q <= {quot_q[DIVIDEND_W-2:0], fits};
        rem_q  <= rem_next;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quot_q[QUOT_W-1:0];

endmodule : hsi_mse_seq_div

// File: rtl/hsi_mse_lanes.sv
// -----------------------------------------------------------------------------
// hsi_mse_lanes
// Multi-lane streaming MSE engine: floor(sum((a-b)^2) / vctr_len) over two
// packed vectors delivered LANES elements per word, with a saturating
// accumulator and a sequential divider (hsi_mse_seq_div).
// Optional feature macro: HM_MSE_MIN_TRACK_EN adds the running-minimum
// outputs min_mse / min_index / min_valid.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clear              synchronous abort/flush to IDLE, all outputs 0
//   start              begin a run (honoured in IDLE or DONE only)
//   vctr_len           element count, sampled at start
//   lib_index          library tag, sampled at start
//   in_valid/in_ready  word handshake; in_ready is high only in ACCUM
//   in_vctr1/in_vctr2  packed words, lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
//   mse_valid          result valid, held in DONE
//   mse_value          floor(acc / vctr_len)
//   mse_index          lib_index of the result
//   mse_overflow       accumulator saturated during this run
//   min_mse, min_index, min_valid   (HM_MSE_MIN_TRACK_EN only)
// -----------------------------------------------------------------------------
module hsi_mse_lanes
  import hsi_mse_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int DATA_WIDTH_ACC = 48,
  parameter int LENGTH_BITS    = 10,
  parameter int LIB_BITS       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    start,
  input  logic [LENGTH_BITS-1:0]  vctr_len,
  input  logic [LIB_BITS-1:0]     lib_index,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_WIDTH-1:0]   in_vctr1,
  input  logic [WORD_WIDTH-1:0]   in_vctr2,
  output logic                    mse_valid,
  output logic [2*DATA_WIDTH-1:0] mse_value,
  output logic [LIB_BITS-1:0]     mse_index,
  output logic                    mse_overflow
`ifdef HM_MSE_MIN_TRACK_EN
  ,
  output logic [2*DATA_WIDTH-1:0] min_mse,
  output logic [LIB_BITS-1:0]     min_index,
  output logic                    min_valid
`endif
);

  localparam int LANES = WORD_WIDTH / DATA_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int ACC   = DATA_WIDTH_ACC;
  localparam int LW    = LENGTH_BITS;
  localparam int SQ_W  = 2 * DW;
  localparam int SUM_W = SQ_W + $clog2(LANES);
  // One spare bit above the wider of acc / lane sum exposes the carry used
  // to detect saturation.
  localparam int ADD_W = ((ACC > SUM_W) ? ACC : SUM_W) + 1;
  localparam logic [ADD_W-1:0] ACC_MAX = {{(ADD_W - ACC){1'b0}}, {ACC{1'b1}}};

  hsi_mse_lanes_state_t state_q;

  logic [LW-1:0]       len_q;
  logic [LW-1:0]       num_words_q;
  logic [LW-1:0]       last_lanes_q;   // valid lanes in final word, 0 = all
  logic [LW-1:0]       wcnt_q;
  logic [LIB_BITS-1:0] idx_q;
  logic [1:0]          drain_cnt_q;

  logic                start_go;
  logic                accept;
  logic                last_word;
  logic [LW:0]         len_round;

  logic [LANES-1:0][DW-1:0]   s1_diff_d;
  logic [LANES-1:0][DW-1:0]   s1_diff_q;
  logic [LANES-1:0][SQ_W-1:0] s2_sq_q;
  logic                       s1_vld_q;
  logic                       s2_vld_q;
  logic [ADD_W-1:0]           lane_sum;
  logic [ADD_W-1:0]           acc_sum;
  logic [ACC-1:0]             acc_q;
  logic                       ovf_q;

  logic                div_start;
  logic                div_busy;
  logic                div_done;
  logic                div_finish;
  logic [SQ_W-1:0]     div_quot;

  logic                done_load;
  logic [SQ_W-1:0]     done_val;
  logic [LIB_BITS-1:0] done_idx;

  assign start_go   = start && ((state_q == MSE_IDLE) || (state_q == MSE_DONE));
  assign in_ready   = (state_q == MSE_ACCUM);
  assign accept     = in_valid && in_ready;
  assign last_word  = (wcnt_q == num_words_q - LW'(1));
  assign len_round  = {1'b0, vctr_len} + (LW + 1)'(LANES - 1);
  assign div_start  = (state_q == MSE_DRAIN) &&
                      (drain_cnt_q == 2'(HM_MSE_PIPE_STAGES - 1));
  assign div_finish = div_done && !div_busy;
  assign mse_overflow = ovf_q;

  // S1: per-lane absolute difference; lanes past the vector end in the last
  // word contribute nothing.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    s1_diff_d = '0;
    for (int k = 0; k < LANES; k++) begin
      s1_diff_d[k] = (in_vctr1[k*DW +: DW] > in_vctr2[k*DW +: DW])
                   ? in_vctr1[k*DW +: DW] - in_vctr2[k*DW +: DW]
                   : in_vctr2[k*DW +: DW] - in_vctr1[k*DW +: DW];
      if (last_word && (last_lanes_q != '0) && (LW'(k) >= last_lanes_q)) begin
        s1_diff_d[k] = '0;
      end
    end
  end

  // NOTE: the datapath stage registers carry no reset; the s*_vld_q bits
  // decide when their contents count, so reset fan-out stays on control only.
  always_ff @(posedge clk) begin
    s1_diff_q <= s1_diff_d;
    for (int k = 0; k < LANES; k++) begin
      s2_sq_q[k] <= SQ_W'(s1_diff_q[k]) * SQ_W'(s1_diff_q[k]);
    end
  end

  // S3: lane sum and saturating add.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + ADD_W'(s2_sq_q[k]);
    end
    acc_sum = ADD_W'(acc_q) + lane_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else if (clear) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      s2_vld_q <= s1_vld_q;
      if (start_go) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (s2_vld_q) begin
        if (acc_sum > ACC_MAX) begin
          acc_q <= '1;
          ovf_q <= 1'b1;
        end else begin
          acc_q <= acc_sum[ACC-1:0];
        end
      end
    end
  end

  hsi_mse_seq_div #(
    .DIVIDEND_W (ACC),
    .DIVISOR_W  (LW),
    .QUOT_W     (SQ_W)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear),
    .start_i    (div_start),
    .dividend_i (acc_q),
    .divisor_i  (len_q),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quot)
  );

  // Result loaded on entry to DONE: zero-length runs skip the divider.
  always_comb begin
    done_load = 1'b0;
    done_val  = '0;
    done_idx  = idx_q;
    if (start_go && (vctr_len == '0)) begin
      done_load = 1'b1;
      done_idx  = lib_index;
    end else if ((state_q == MSE_DIVIDE) && div_finish) begin
      done_load = 1'b1;
      done_val  = div_quot;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= MSE_IDLE;
      len_q        <= '0;
      num_words_q  <= '0;
      last_lanes_q <= '0;
      wcnt_q       <= '0;
      idx_q        <= '0;
      drain_cnt_q  <= '0;
      mse_valid    <= 1'b0;
      mse_value    <= '0;
      mse_index    <= '0;
`ifdef HM_MSE_MIN_TRACK_EN
      min_mse      <= '0;
      min_index    <= '0;
      min_valid    <= 1'b0;
`endif
    end else if (clear) begin
      state_q      <= MSE_IDLE;
      len_q        <= '0;
      num_words_q  <= '0;
      last_lanes_q <= '0;
      wcnt_q       <= '0;
      idx_q        <= '0;
      drain_cnt_q  <= '0;
      mse_valid    <= 1'b0;
      mse_value    <= '0;
      mse_index    <= '0;
`ifdef HM_MSE_MIN_TRACK_EN
      min_mse      <= '0;
      min_index    <= '0;
      min_valid    <= 1'b0;
`endif
    end else begin
      case (state_q)
        MSE_IDLE, MSE_DONE: begin
          if (start) begin
            len_q        <= vctr_len;
            idx_q        <= lib_index;
            num_words_q  <= LW'(len_round / (LW + 1)'(LANES));
            last_lanes_q <= vctr_len % LW'(LANES);
            wcnt_q       <= '0;
            state_q      <= (vctr_len == '0) ? MSE_DONE : MSE_ACCUM;
          end
        end
        MSE_ACCUM: begin
          if (accept) begin
            wcnt_q <= wcnt_q + LW'(1);
            if (last_word) begin
              state_q     <= MSE_DRAIN;
              drain_cnt_q <= '0;
            end
          end
        end
        MSE_DRAIN: begin
          if (div_start) state_q <= MSE_DIVIDE;
          else           drain_cnt_q <= drain_cnt_q + 2'd1;
        end
        MSE_DIVIDE: begin
          if (div_finish) state_q <= MSE_DONE;
        end
        default: state_q <= MSE_IDLE;
      endcase

      if (start_go) mse_valid <= 1'b0;
      if (done_load) begin
        mse_valid <= 1'b1;
        mse_value <= done_val;
        mse_index <= done_idx;
`ifdef HM_MSE_MIN_TRACK_EN
        // Strict compare: an equal later result keeps the earlier entry.
        if (!min_valid || (done_val < min_mse)) begin
          min_mse   <= done_val;
          min_index <= done_idx;
          min_valid <= 1'b1;
        end
`endif
      end
    end
  end

endmodule : hsi_mse_lanes

// File: tb/tb_hsi_mse_lanes.sv
// -----------------------------------------------------------------------------
// tb_hsi_mse_lanes
// Directed bench for hsi_mse_lanes. Two instances share stimulus: the default
// 48-bit accumulator and a 32-bit accumulator variant. Expected results come
// from a whole-vector arithmetic model (sum of squares, clamp, integer divide);
// a compare process checks every cycle a result is valid, including the
// arrival cycle. Literal expectations pin the model on the key vectors.
// Define HM_MSE_MIN_TRACK_EN to exercise the running-minimum outputs.
// -----------------------------------------------------------------------------
module tb_hsi_mse_lanes;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic [9:0]  vctr_len;
  logic [7:0]  lib_index;
  logic        in_valid;
  logic [31:0] in_vctr1;
  logic [31:0] in_vctr2;

  logic        rdy48, val48, ovf48;
  logic [31:0] mse48;
  logic [7:0]  idx48;
  logic        rdy32, val32, ovf32;
  logic [31:0] mse32;
  logic [7:0]  idx32;
`ifdef HM_MSE_MIN_TRACK_EN
  logic [31:0] min_mse48, min_mse32;
  logic [7:0]  min_idx48, min_idx32;
  logic        min_val48, min_val32;
`endif

  always #5 clk = ~clk;

  hsi_mse_lanes dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
    .vctr_len(vctr_len), .lib_index(lib_index),
    .in_valid(in_valid), .in_ready(rdy48),
    .in_vctr1(in_vctr1), .in_vctr2(in_vctr2),
    .mse_valid(val48), .mse_value(mse48), .mse_index(idx48),
    .mse_overflow(ovf48)
`ifdef HM_MSE_MIN_TRACK_EN
    , .min_mse(min_mse48), .min_index(min_idx48), .min_valid(min_val48)
`endif
  );

  hsi_mse_lanes #(.DATA_WIDTH_ACC(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
    .vctr_len(vctr_len), .lib_index(lib_index),
    .in_valid(in_valid), .in_ready(rdy32),
    .in_vctr1(in_vctr1), .in_vctr2(in_vctr2),
    .mse_valid(val32), .mse_value(mse32), .mse_index(idx32),
    .mse_overflow(ovf32)
`ifdef HM_MSE_MIN_TRACK_EN
    , .min_mse(min_mse32), .min_index(min_idx32), .min_valid(min_val32)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int unsigned e1 [64];
  int unsigned e2 [64];

  // Expectations consumed by the compare process.
  longint unsigned exp_val48 = 0, exp_val32 = 0;
  bit              exp_ovf48 = 0, exp_ovf32 = 0;
  int              exp_idx   = 0;
  int              exp_cyc48 = 0, exp_cyc32 = 0;
  bit              prev48 = 0, prev32 = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Whole-vector model: clamping each partial sum equals clamping the total.
  function automatic void model(input int len, input int acc_w,
                                output longint unsigned val, output bit ovf);
    longint unsigned total = 0;
    longint unsigned lim;
    longint unsigned d;
    lim = (64'd1 << acc_w) - 64'd1;
    for (int i = 0; i < len; i++) begin
      d = (e1[i] > e2[i]) ? longint'(e1[i] - e2[i]) : longint'(e2[i] - e1[i]);
      total += d * d;
    end
    ovf = (total > lim);
    if (ovf) total = lim;
    val = (len == 0) ? 64'd0 : ((total / longint'(len)) & 64'hFFFF_FFFF);
  endfunction

  task automatic fill_const(input int len, input int unsigned a, input int unsigned b);
    for (int i = 0; i < 64; i++) begin
      e1[i] = (i < len) ? a : 32'hFFFF;
      e2[i] = (i < len) ? b : 32'h0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (val48) begin
        check("cmp48_value", mse48, exp_val48);
        check("cmp48_ovf", ovf48, exp_ovf48);
        check("cmp48_index", idx48, exp_idx);
        if (!prev48) check("cmp48_arrival_cycle", cyc, exp_cyc48);
      end
      if (val32) begin
        check("cmp32_value", mse32, exp_val32);
        check("cmp32_ovf", ovf32, exp_ovf32);
        check("cmp32_index", idx32, exp_idx);
        if (!prev32) check("cmp32_arrival_cycle", cyc, exp_cyc32);
      end
    end
    prev48 = val48;
    prev32 = val32;
  end

  task automatic wait_results();
    int n = 0;
    while (!(val48 && val32) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("result_wait_bound", (val48 && val32), 1);
  endtask

  // Issues one run from the shared element arrays. poke raises a stray start
  // mid-run; gaps inserts idle cycles between words.
  task automatic run_vec(input int len, input int idx, input bit gaps,
                         input bit poke, input bit wait_done);
    longint unsigned v48, v32;
    bit o48, o32;
    int words;
    int last_edge = 0;
    model(len, 48, v48, o48);
    model(len, 32, v32, o32);
    vctr_len  = 10'(len);
    lib_index = 8'(idx);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    exp_val48 = v48; exp_ovf48 = o48;
    exp_val32 = v32; exp_ovf32 = o32;
    exp_idx   = idx;
    exp_cyc48 = cyc; exp_cyc32 = cyc;
    words = (len + 1) / 2;
    for (int w = 0; w < words; w++) begin
      bit got = 0;
      int n = 0;
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      in_vctr1 = {16'(e1[2*w+1]), 16'(e1[2*w])};
      in_vctr2 = {16'(e2[2*w+1]), 16'(e2[2*w])};
      in_valid = 1'b1;
      if (poke && w == 2) begin
        start     = 1'b1;
        vctr_len  = 10'd3;
        lib_index = 8'hAA;
      end
      while (!got && n < 20) begin
        @(negedge clk);
        got = rdy48;
        if (got) last_edge = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        n++;
      end
      if (!got) check("accept_bound", 0, 1);
      if (w == 0) vctr_len = 10'($urandom_range(1, 1023));
    end
    in_valid = 1'b0;
    if (len != 0) begin
      exp_cyc48 = last_edge + 52;
      exp_cyc32 = last_edge + 36;
    end
    if (wait_done) wait_results();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; vctr_len = '0; lib_index = '0;
    in_valid = 1'b0; in_vctr1 = '0; in_vctr2 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_mse_valid", val48, 0);
    check("reset_mse_value", mse48, 0);
    check("reset_mse_index", idx48, 0);
    check("reset_overflow", ovf48, 0);
    check("reset_in_ready", rdy48, 0);
    check("reset_valid32", val32, 0);

    // in_valid while idle must not open the input.
    in_valid = 1'b1; in_vctr1 = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check("idle_in_ready", rdy48, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Zero-length run: DONE right after start, no input phase.
    fill_const(0, 0, 0);
    run_vec(0, 3, 0, 0, 0);
    @(negedge clk);
    check("t3_valid", val48, 1);
    check("t3_value", mse48, 0);
    check("t3_in_ready", rdy48, 0);
    repeat (3) @(negedge clk);
    check("t3_in_ready_later", rdy48 | rdy32, 0);

    // Test 1: constant difference of 3.
    fill_const(24, 10, 7);
    begin
      longint unsigned mv; bit mo;
      model(24, 48, mv, mo);
      check("t1_model_value", mv, 9);
    end
    run_vec(24, 5, 0, 1, 1);
    check("t1_value", mse48, 9);
    check("t1_overflow", ovf48, 0);
    check("t1_index", idx48, 5);

    // Test 2: odd length, garbage in the masked lane.
    fill_const(5, 0, 0);
    e1[0] = 3; e2[0] = 1; e1[1] = 0; e2[1] = 2; e1[2] = 5; e2[2] = 5;
    e1[3] = 7; e2[3] = 7; e1[4] = 9; e2[4] = 9;
    run_vec(5, 12, 0, 0, 1);
    check("t2_value", mse48, 1);
    check("t2_value32", mse32, 1);

    // Test 4: large pixels, then saturation of the 32-bit accumulator.
    fill_const(4, 32'h3FFF, 0);
    run_vec(4, 20, 0, 0, 1);
    check("t4_value48", mse48, 32'h0FFF_8001);
    check("t4_value32", mse32, 32'h0FFF_8001);
    check("t4_ovf32", ovf32, 0);
    fill_const(4, 32'hFFFF, 0);
    run_vec(4, 21, 0, 0, 1);
    check("t4b_ovf32", ovf32, 1);
    check("t4b_value32", mse32, 32'h3FFF_FFFF);
    check("t4b_ovf48", ovf48, 0);
    check("t4b_value48", mse48, 32'hFFFE_0001);

    // Test 5: handshake gaps, then abort during the divide.
    fill_const(24, 10, 7);
    run_vec(24, 9, 1, 0, 1);
    check("t5_gap_value", mse48, 9);
    run_vec(24, 10, 1, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    do_clear();
    @(negedge clk);
    check("t5_clr_valid", val48, 0);
    check("t5_clr_value", mse48, 0);
    check("t5_clr_index", idx48, 0);
    check("t5_clr_in_ready", rdy48, 0);
    check("t5_clr_valid32", val32, 0);
    repeat (60) @(negedge clk);
    check("t5_stays_idle", val48 | val32, 0);
    fill_const(5, 0, 0);
    e1[0] = 3; e2[0] = 1; e1[1] = 0; e2[1] = 2; e1[2] = 5; e2[2] = 5;
    e1[3] = 7; e2[3] = 7; e1[4] = 9; e2[4] = 9;
    run_vec(5, 13, 1, 0, 1);
    check("t5_post_clear_value", mse48, 1);

`ifdef HM_MSE_MIN_TRACK_EN
    // Test 6: running minimum with a tie.
    do_clear();
    @(negedge clk);
    check("t6_min_cleared", min_val48, 0);
    fill_const(24, 10, 7);
    run_vec(24, 5, 0, 0, 1);
    fill_const(2, 2, 0);
    run_vec(2, 6, 0, 0, 1);
    run_vec(2, 7, 0, 0, 1);
    check("t6_min_mse", min_mse48, 4);
    check("t6_min_index", min_idx48, 6);
    check("t6_min_valid", min_val48, 1);
    check("t6_min_index32", min_idx32, 6);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hsi_mse_lanes
